// File: rtl/hms_time_counter_if.sv
// ============================================================================
// Module   : hms_time_counter_if
// Brief    : Button inputs and display-stage outputs of the time-of-day counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hms_time_counter_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [1:0] mode;
    logic       sec_tick;
    logic [7:0] sec_bcd;
    logic [3:0] val3;
    logic [3:0] val2;
    logic [3:0] val1;
    logic [3:0] val0;
    logic       dot3;
    logic       dot2;
    logic       dot1;
    logic       dot0;

    modport master (
        output btn_mode, btn_inc,
        input  mode, sec_tick, sec_bcd, val3, val2, val1, val0,
        input  dot3, dot2, dot1, dot0
    );

    modport slave (
        input  btn_mode, btn_inc,
        output mode, sec_tick, sec_bcd, val3, val2, val1, val0,
        output dot3, dot2, dot1, dot0
    );
endinterface

`default_nettype wire

// File: rtl/hms_time_counter.sv
// ============================================================================
// Module   : hms_time_counter
// Brief    : 24-hour BCD hh:mm:ss counter with two-button hour/minute setting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hms_time_counter #(
    parameter int TICK_DIV = 100_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    hms_time_counter_if.slave bus
);

    localparam int              c_PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_TICK_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_HALF     = c_PW'(TICK_DIV / 2);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SET_HR  = 2'd1,
        S_SET_MIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_nxt;

    logic [1:0] r_hr_t;
    logic [3:0] r_hr_u;
    logic [2:0] r_min_t;
    logic [3:0] r_min_u;
    logic [2:0] r_sec_t;
    logic [3:0] r_sec_u;

    logic [1:0] w_hr_t_nxt;
    logic [3:0] w_hr_u_nxt;
    logic [2:0] w_min_t_nxt;
    logic [3:0] w_min_u_nxt;
    logic [2:0] w_sec_t_nxt;
    logic [3:0] w_sec_u_nxt;

    logic w_tick;
    logic w_blink;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hr_wrap;
    logic w_sec_inc;
    logic w_sec_clr;
    logic w_min_inc;
    logic w_hr_inc;

    assign w_tick     = (r_presc == c_TICK_MAX);
    assign w_blink    = (r_presc < c_HALF);
    assign w_sec_wrap = (r_sec_t == 3'd5) && (r_sec_u == 4'd9);
    assign w_min_wrap = (r_min_t == 3'd5) && (r_min_u == 4'd9);
    assign w_hr_wrap  = (r_hr_t == 2'd2) && (r_hr_u == 4'd3);

    // Mode changes take priority over increments in the same cycle.
    always_comb begin : p_fsm_next
        w_state_nxt = r_state;
        w_sec_inc   = 1'b0;
        w_sec_clr   = 1'b0;
        w_min_inc   = 1'b0;
        w_hr_inc    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (bus.btn_mode) begin
                    w_state_nxt = S_SET_HR;
                end
                w_sec_inc = w_tick;
                w_min_inc = w_tick && w_sec_wrap;
                w_hr_inc  = w_tick && w_sec_wrap && w_min_wrap;
            end
            S_SET_HR: begin
                if (bus.btn_mode) begin
                    w_state_nxt = S_SET_MIN;
                end else begin
                    w_hr_inc = bus.btn_inc;
                end
            end
            S_SET_MIN: begin
                if (bus.btn_mode) begin
                    w_state_nxt = S_RUN;
                    w_sec_clr   = 1'b1;
                end else begin
                    w_min_inc = bus.btn_inc;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_comb begin : p_time_next
        w_sec_t_nxt = r_sec_t;
        w_sec_u_nxt = r_sec_u;
        w_min_t_nxt = r_min_t;
        w_min_u_nxt = r_min_u;
        w_hr_t_nxt  = r_hr_t;
        w_hr_u_nxt  = r_hr_u;

        if (w_sec_clr) begin
            w_sec_t_nxt = 3'd0;
            w_sec_u_nxt = 4'd0;
        end else if (w_sec_inc) begin
            if (r_sec_u == 4'd9) begin
                w_sec_u_nxt = 4'd0;
                w_sec_t_nxt = w_sec_wrap ? 3'd0 : r_sec_t + 3'd1;
            end else begin
                w_sec_u_nxt = r_sec_u + 4'd1;
            end
        end

        if (w_min_inc) begin
            if (r_min_u == 4'd9) begin
                w_min_u_nxt = 4'd0;
                w_min_t_nxt = w_min_wrap ? 3'd0 : r_min_t + 3'd1;
            end else begin
                w_min_u_nxt = r_min_u + 4'd1;
            end
        end

        // Hours roll 23 -> 00 before the units-digit 9 -> 0 carry is considered.
        if (w_hr_inc) begin
            if (w_hr_wrap) begin
                w_hr_t_nxt = 2'd0;
                w_hr_u_nxt = 4'd0;
            end else if (r_hr_u == 4'd9) begin
                w_hr_t_nxt = r_hr_t + 2'd1;
                w_hr_u_nxt = 4'd0;
            end else begin
                w_hr_u_nxt = r_hr_u + 4'd1;
            end
        end
    end

    // Leaving SET_MIN restarts the second so the next tick is a full period away.
    always_comb begin : p_presc_next
        if (w_sec_clr || w_tick) begin
            w_presc_nxt = '0;
        end else begin
            w_presc_nxt = r_presc + c_PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
        if (!rst_n) begin
            r_state <= S_RUN;
            r_presc <= '0;
            r_hr_t  <= 2'd0;
            r_hr_u  <= 4'd0;
            r_min_t <= 3'd0;
            r_min_u <= 4'd0;
            r_sec_t <= 3'd0;
            r_sec_u <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_hr_t  <= w_hr_t_nxt;
            r_hr_u  <= w_hr_u_nxt;
            r_min_t <= w_min_t_nxt;
            r_min_u <= w_min_u_nxt;
            r_sec_t <= w_sec_t_nxt;
            r_sec_u <= w_sec_u_nxt;
        end
    end

    always_comb begin : p_dots
        bus.dot3 = 1'b0;
        bus.dot2 = 1'b0;
        bus.dot1 = 1'b0;
        bus.dot0 = 1'b0;
        case (r_state)
            S_RUN: begin
                bus.dot2 = w_blink;
            end
            S_SET_HR: begin
                bus.dot3 = w_blink;
                bus.dot2 = w_blink;
            end
            S_SET_MIN: begin
                bus.dot1 = w_blink;
                bus.dot0 = w_blink;
            end
            default: begin
                bus.dot2 = w_blink;
            end
        endcase
    end

    assign bus.mode     = r_state;
    assign bus.sec_tick = w_tick;
    assign bus.sec_bcd  = {1'b0, r_sec_t, r_sec_u};
    assign bus.val3     = {2'b00, r_hr_t};
    assign bus.val2     = r_hr_u;
    assign bus.val1     = {1'b0, r_min_t};
    assign bus.val0     = r_min_u;

endmodule

`default_nettype wire
